vx_rsp_router: RTL and testbench
================================

# vx_rsp_router

Response-return router for the request side of an arbiter: it records the grant index of every request issued downstream and steers the in-order responses back to the requester that won each grant. It sits between a shared memory or functional-unit port and the `NUM_REQS` clients multiplexed onto it. This is the reverse path of the request arbitration.

## Interface
Parameters:
- `NUM_REQS`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 32: response payload width.
- `MAX_PENDING`, 8: outstanding-request capacity (power of 2, ≥2).
- `LOG_NUM_REQS`, `LOG2UP(NUM_REQS)`: index width.
- `CNT_WIDTH`, `LOG2UP(MAX_PENDING)+1`: occupancy width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_fire` in 1: a request was issued downstream this cycle.
- `req_index` in `LOG_NUM_REQS`: grant index of that request.
- `req_ready` out 1: tracking slot free; upstream must gate issue with it.
- `rsp_valid_in` in 1: downstream response valid.
- `rsp_data_in` in `DATA_WIDTH`: response payload.
- `rsp_ready_in` out 1: response accepted when high with `rsp_valid_in`.
- `rsp_valid_out` out `NUM_REQS`: one-hot response valid per requester.
- `rsp_data_out` out `DATA_WIDTH`: shared response bus.
- `rsp_ready_out` in `NUM_REQS`: per-requester ready.
- `pending_count` out `CNT_WIDTH`: outstanding requests whose responses have not yet been accepted.
- `overflow_err` out 1: sticky; `req_fire` was asserted while `req_ready` was low.
- `underflow_err` out 1: sticky; `rsp_valid_in` was asserted while `pending_count` was 0.

## Operation
- Index FIFO of depth `MAX_PENDING` with read/write pointers modulo `MAX_PENDING` and count 0..`MAX_PENDING`.
- Push: `req_fire && req_ready` writes `req_index` and increments the write pointer.
- `req_ready = (count != MAX_PENDING)`. A pop in the same cycle does not free a slot for a push while full.
- Output stage: one register holding `out_valid`, `out_idx` and `out_data`.
- `out_drain = out_valid && rsp_ready_out[out_idx]`.
- `rsp_ready_in = (count != 0) && (!out_valid || out_drain)`. There is no bypass: an index pushed this cycle is poppable next cycle.
- Response accept (`rsp_valid_in && rsp_ready_in`):
  - pop the FIFO head into `out_idx`;
  - load `rsp_data_in` into `out_data`;
  - set `out_valid`.
- Drain without accept clears `out_valid`. `out_data` holds its value.
- `rsp_valid_out = out_valid ? (1 << out_idx) : 0`. `rsp_data_out = out_data`.
- `rsp_ready_out` bits other than `out_idx` are ignored.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged.
- Errors:
  - `overflow_err` sets on `req_fire && !req_ready`. The request is dropped and no state changes.
  - `underflow_err` sets on `rsp_valid_in && count == 0`. The response is not accepted.
  - Both error flags clear only on reset.

## Timing
- Reset (asynchronous assert, release on a clock edge): pointers 0, count 0, `out_valid` 0, `out_idx` 0, `out_data` 0, both errors 0.
- Output values in reset: `req_ready` 1, `rsp_ready_in` 0, `rsp_valid_out` 0, `pending_count` 0.
- Latency: a response accepted at edge N is visible on `rsp_valid_out` and `rsp_data_out` after N. It stays stable until drained.
- Throughput: one response per cycle when the target requester's ready is held high.
- Reset mid-operation discards all pending indices and the buffered response. No partial output survives.
- `pending_count` is registered and reflects pushes and pops of the previous edge.

## Structure
- No shared package types are needed. Widths are derived from parameters locally.
- Error bit positions, if ever exported as a vector, go in the shared `VX_gpu_pkg`.
- Natural sub-module: `vx_index_fifo`, a parameterised depth/width FIFO with count, full and empty flags. The top level adds the output register, one-hot decode and error logic.

## Test plan
- Reset check: assert `reset`=0 mid-traffic → all outputs return to their reset values immediately (asynchronously), and `req_ready`=1.
- In-order routing: issue indices 2, 0, 3, then send responses A, B, C with all `rsp_ready_out`=1111 → `rsp_valid_out` sequence 0100, 0001, 1000 carrying A, B, C. `pending_count` goes 3→0.
- Backpressure: index 1 pending, response D accepted, `rsp_ready_out[1]`=0 for 5 cycles → D is held on `rsp_data_out`, `rsp_ready_in`=0 while a second index is pending, and release occurs the cycle `rsp_ready_out[1]`=1.
- Full boundary: 8 pushes with no responses → `req_ready`=0 and `pending_count`=8. A 9th `req_fire` sets `overflow_err`, leaves count at 8, and leaves the FIFO contents intact.
- Simultaneous push/pop at count 4 → count stays 4, and the wrap-around of both pointers past 7 preserves order across 20 transactions.
- Underflow: `rsp_valid_in`=1 with count 0 → `rsp_ready_in`=0, `underflow_err`=1 sticky until reset.

Source files
------------

// File: rtl/vx_rsp_router_pkg.sv
// Shared helpers for the response router slice.
// Widths are derived locally from parameters; only the log2 helper is shared.
package vx_rsp_router_pkg;

  function automatic int unsigned LOG2UP(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_index_fifo.sv
// Parameterised depth/width FIFO with occupancy count, full and empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module vx_index_fifo
  import vx_rsp_router_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned CNT_WIDTH = LOG2UP(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_pop,
  output logic [WIDTH-1:0]     o_data,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int unsigned PTR_W = LOG2UP(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == CNT_WIDTH'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vx_rsp_router.sv
// Response-return router: remembers the grant index of each issued request and
// steers in-order responses back to the winning requester through one output register.
module vx_rsp_router
  import vx_rsp_router_pkg::*;
#(
  parameter int unsigned NUM_REQS     = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned LOG_NUM_REQS = LOG2UP(NUM_REQS),
  parameter int unsigned CNT_WIDTH    = LOG2UP(MAX_PENDING) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_fire,
  input  logic [LOG_NUM_REQS-1:0] req_index,
  output logic                    req_ready,
  input  logic                    rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]   rsp_data_in,
  output logic                    rsp_ready_in,
  output logic [NUM_REQS-1:0]     rsp_valid_out,
  output logic [DATA_WIDTH-1:0]   rsp_data_out,
  input  logic [NUM_REQS-1:0]     rsp_ready_out,
  output logic [CNT_WIDTH-1:0]    pending_count,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  logic                    r_out_valid;
  logic [LOG_NUM_REQS-1:0] r_out_idx;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_overflow;
  logic                    r_underflow;

  logic                    w_full;
  logic                    w_empty;
  logic [LOG_NUM_REQS-1:0] w_head_idx;
  logic                    w_push;
  logic                    w_accept;
  logic                    w_sel_ready;
  logic                    w_out_drain;

  vx_index_fifo #(
    .DEPTH     (MAX_PENDING),
    .WIDTH     (LOG_NUM_REQS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_index_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (req_index),
    .i_pop   (w_accept),
    .o_data  (w_head_idx),
    .o_count (pending_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Readiness comes from the registered count only, so a pop never frees a
  // slot for a same-cycle push and a fresh index is poppable one cycle later.
  assign req_ready    = !w_full;
  assign w_push       = req_fire && req_ready;
  assign w_out_drain  = r_out_valid && w_sel_ready;
  assign rsp_ready_in = !w_empty && (!r_out_valid || w_out_drain);
  assign w_accept     = rsp_valid_in && rsp_ready_in;

  // Selected requester's ready; bits other than the buffered index are ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (r_out_idx == LOG_NUM_REQS'(i)) begin
        w_sel_ready = rsp_ready_out[i];
      end
    end
  end

  always_comb begin
    rsp_valid_out = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      rsp_valid_out[i] = r_out_valid && (r_out_idx == LOG_NUM_REQS'(i));
    end
  end

  assign rsp_data_out  = r_out_data;
  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_idx   <= w_head_idx;
      r_out_data  <= rsp_data_in;
    end else if (w_out_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (req_fire && !req_ready) begin
        r_overflow <= 1'b1;
      end
      if (rsp_valid_in && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_rsp_router.sv
// Randomised and directed bench for vx_rsp_router with a queue-based reference
// model and a scoreboard drained by an independent output monitor.
module tb_vx_rsp_router;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_fire;
  logic [1:0]    req_index;
  logic          req_ready;
  logic          rsp_valid_in;
  logic [DW-1:0] rsp_data_in;
  logic          rsp_ready_in;
  logic [NR-1:0] rsp_valid_out;
  logic [DW-1:0] rsp_data_out;
  logic [NR-1:0] rsp_ready_out;
  logic [3:0]    pending_count;
  logic          overflow_err;
  logic          underflow_err;

  always #5 clk = ~clk;

  vx_rsp_router #(
    .NUM_REQS    (NR),
    .DATA_WIDTH  (DW),
    .MAX_PENDING (MP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_fire      (req_fire),
    .req_index     (req_index),
    .req_ready     (req_ready),
    .rsp_valid_in  (rsp_valid_in),
    .rsp_data_in   (rsp_data_in),
    .rsp_ready_in  (rsp_ready_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_ready_out (rsp_ready_out),
    .pending_count (pending_count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } rsp_t;

  // Reference model: indices awaiting a response, the buffered response, sticky errors.
  int          pend[$];
  rsp_t        sb[$];
  bit          m_valid;
  int          m_idx;
  logic [31:0] m_data;
  bit          m_ovf;
  bit          m_unf;
  bit          m_full, m_drain, m_rin, m_acc, m_push;
  bit          mon_rin;
  logic [3:0]  mon_oh;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        pend.delete();
        sb.delete();
        m_valid = 0;
        m_idx   = 0;
        m_data  = '0;
        m_ovf   = 0;
        m_unf   = 0;
      end else begin
        m_full  = (pend.size() == MP);
        m_drain = m_valid && rsp_ready_out[m_idx];
        m_rin   = (pend.size() != 0) && (!m_valid || m_drain);
        m_acc   = rsp_valid_in && m_rin;
        m_push  = req_fire && !m_full;
        if (req_fire && m_full) m_ovf = 1;
        if (rsp_valid_in && pend.size() == 0) m_unf = 1;
        if (m_acc) begin
          m_idx   = pend.pop_front();
          m_data  = rsp_data_in;
          m_valid = 1;
          sb.push_back('{m_idx, m_data});
        end else if (m_drain) begin
          m_valid = 0;
        end
        if (m_push) pend.push_back(int'(req_index));
      end
    end
  end

  // Monitor: inputs are stable at the falling edge, so the upcoming drain is known here.
  initial begin
    forever begin
      @(negedge clk);
      mon_rin = (pend.size() != 0) && (!m_valid || rsp_ready_out[m_idx]);
      chk("pending_count", pending_count, pend.size());
      chk("req_ready", req_ready, pend.size() != MP);
      chk("rsp_ready_in", rsp_ready_in, mon_rin);
      chk("overflow_err", overflow_err, m_ovf);
      chk("underflow_err", underflow_err, m_unf);
      chk("rsp_data_hold", rsp_data_out, m_data);
      if (sb.size() != 0) begin
        mon_oh = 4'(1 << sb[0].idx);
        chk("rsp_valid_route", rsp_valid_out, mon_oh);
        chk("rsp_data_route", rsp_data_out, sb[0].data);
        if (rsp_valid_out != '0 && rsp_ready_out[sb[0].idx]) void'(sb.pop_front());
      end else begin
        chk("rsp_valid_idle", rsp_valid_out, 4'b0000);
      end
    end
  end

  task automatic step(input bit f, input int idx, input bit v, input logic [31:0] d,
                      input logic [3:0] ro);
    req_fire      = f;
    req_index     = 2'(idx);
    rsp_valid_in  = v;
    rsp_data_in   = d;
    rsp_ready_out = ro;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid_out"}, rsp_valid_out, 4'b0000);
    chk({tag, "_rsp_data_out"}, rsp_data_out, 32'h0);
    chk({tag, "_pending_count"}, pending_count, 4'd0);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_rsp_ready_in"}, rsp_ready_in, 1'b0);
    chk({tag, "_overflow_err"}, overflow_err, 1'b0);
    chk({tag, "_underflow_err"}, underflow_err, 1'b0);
  endtask

  initial begin
    reset         = 1'b0;
    req_fire      = 1'b0;
    req_index     = '0;
    rsp_valid_in  = 1'b0;
    rsp_data_in   = '0;
    rsp_ready_out = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("init");
    reset = 1'b1;

    // In-order routing: indices 2,0,3 then responses A,B,C.
    step(1, 2, 0, 0, 4'hF);
    step(1, 0, 0, 0, 4'hF);
    step(1, 3, 0, 0, 4'hF);
    step(0, 0, 1, 32'hAAAA_0001, 4'hF);
    step(0, 0, 1, 32'hBBBB_0002, 4'hF);
    step(0, 0, 1, 32'hCCCC_0003, 4'hF);
    step(0, 0, 0, 0, 4'hF);
    step(0, 0, 0, 0, 4'hF);

    // Backpressure on requester 1 while a second index is pending.
    step(1, 1, 0, 0, 4'hF);
    step(1, 2, 0, 0, 4'hF);
    step(0, 0, 1, 32'hDDDD_0004, 4'b1101);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hEEEE_0005, 4'b1101);
    step(0, 0, 1, 32'hEEEE_0005, 4'hF);
    step(0, 0, 0, 0, 4'hF);
    step(0, 0, 0, 0, 4'hF);

    // Full boundary and overflow; contents must drain intact afterwards.
    for (int i = 0; i < MP; i++) step(1, (i * 3) % NR, 0, 0, 4'hF);
    step(1, 3, 0, 0, 4'hF);
    for (int i = 0; i < MP; i++) step(0, 0, 1, $urandom, 4'hF);
    step(0, 0, 0, 0, 4'hF);

    // Simultaneous push/pop at count 4 across pointer wrap.
    for (int i = 0; i < 4; i++) step(1, $urandom_range(0, NR - 1), 0, 0, 4'hF);
    for (int i = 0; i < 20; i++) step(1, $urandom_range(0, NR - 1), 1, $urandom, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom, 4'hF);
    step(0, 0, 0, 0, 4'hF);
    step(0, 0, 0, 0, 4'hF);

    // Underflow with nothing pending.
    step(0, 0, 1, 32'h1234_5678, 4'hF);
    step(0, 0, 0, 0, 4'hF);

    // Asynchronous reset with pending indices and a buffered response.
    step(1, 1, 0, 0, 4'hF);
    step(1, 3, 0, 0, 4'hF);
    step(0, 0, 1, 32'h5555_AAAA, 4'b0000);
    req_fire     = 1'b0;
    rsp_valid_in = 1'b0;
    reset        = 1'b0;
    #1;
    check_reset_outputs("async");
    step(0, 0, 0, 0, 4'hF);
    step(0, 0, 0, 0, 4'hF);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, NR - 1),
           $urandom_range(0, 99) < 50, $urandom,
           ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)));
    end

    reset = 1'b0;
    #1;
    check_reset_outputs("final");
    step(0, 0, 0, 0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
